// File: rtl/jtldtest_ioctl_gen.sv
// Two-pass ioctl download generator: streams len bytes (LFSR or address pattern)
// with one write strobe per WR_PERIOD cycles, flushes, idles for GAP_LEN, then repeats.
module jtldtest_ioctl_gen #(
    parameter int WR_PERIOD = 8,
    parameter int GAP_LEN   = 16,
    parameter int PATTERN   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [24:0] len,
    input  logic [7:0]  seed,
    input  logic        dwnld_busy,
    output logic        downloading,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    output logic        ioctl_wr,
    output logic        pass,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, DWN, FLUSH, GAP, FIN} state_t;

    localparam logic [7:0]  CNT_LAST = 8'(WR_PERIOD - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] gap_q, gap_d;
    logic [24:0] addr_q, addr_d;
    logic [24:0] len_l_q, len_l_d;
    logic [7:0]  seed_l_q, seed_l_d;
    logic [7:0]  dout_q, dout_d;
    logic        wr_q, wr_d;
    logic        pass_q, pass_d;
    logic        dl_q, dl_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    function automatic logic [7:0] lfsr_next(input logic [7:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    function automatic logic [7:0] entry_byte(input logic [7:0] s);
        if (PATTERN == 1) return 8'h00;
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    function automatic logic [7:0] next_byte(input logic [7:0] d, input logic [24:0] a);
        if (PATTERN == 1) return a[7:0];
        return lfsr_next(d);
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        addr_d   = addr_q;
        len_l_d  = len_l_q;
        seed_l_d = seed_l_q;
        dout_d   = dout_q;
        pass_d   = pass_q;
        dl_d     = dl_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (len != 25'd0)) begin
                    state_d  = DWN;
                    len_l_d  = len;
                    seed_l_d = seed;
                    cnt_d    = 8'd0;
                    addr_d   = 25'd0;
                    dout_d   = entry_byte(seed);
                    pass_d   = 1'b0;
                    dl_d     = 1'b1;
                end
            end
            DWN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 8'd0;
                    if (addr_q == len_l_q - 25'd1) begin
                        state_d = FLUSH;
                    end else begin
                        addr_d = addr_q + 25'd1;
                        dout_d = next_byte(dout_q, addr_q + 25'd1);
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FLUSH: begin
                if (!dwnld_busy) begin
                    state_d = GAP;
                    dl_d    = 1'b0;
                    gap_d   = 16'd0;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (!pass_q) begin
                        state_d = DWN;
                        pass_d  = 1'b1;
                        cnt_d   = 8'd0;
                        addr_d  = 25'd0;
                        dout_d  = entry_byte(seed_l_q);
                        dl_d    = 1'b1;
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
                pass_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Strobe lands on the second cycle of every byte slot.
        wr_d   = (state_d == DWN) && (cnt_d == 8'd1);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            gap_q   <= 16'd0;
            addr_q  <= 25'd0;
            dout_q  <= 8'd0;
            wr_q    <= 1'b0;
            pass_q  <= 1'b0;
            dl_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            wr_q    <= wr_d;
            pass_q  <= pass_d;
            dl_q    <= dl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Latched request parameters only matter while busy, so they skip reset.
    always_ff @(posedge clk) begin
        len_l_q  <= len_l_d;
        seed_l_q <= seed_l_d;
    end

    assign downloading = dl_q;
    assign ioctl_addr  = addr_q;
    assign ioctl_dout  = dout_q;
    assign ioctl_wr    = wr_q;
    assign pass        = pass_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_jtldtest_ioctl_gen.sv
// Randomized self-checking bench: predicts byte streams, strobe spacing and
// downloading-window lengths from plain arithmetic and compares cycle by cycle.
module tb_jtldtest_ioctl_gen;
    logic        clk = 1'b0;
    logic        rst, start0, start1, dwnld_busy;
    logic [24:0] len;
    logic [7:0]  seed;
    logic        dl0, wr0, pass0, busy0, done0;
    logic        dl1, wr1, pass1, busy1, done1;
    logic [24:0] addr0, addr1;
    logic [7:0]  dout0, dout1;

    int checks = 0;
    int failures = 0;

    logic        o_dl, o_wr, o_pass, o_busy, o_done;
    logic [24:0] o_addr;
    logic [7:0]  o_dout;

    always #5 clk = ~clk;

    jtldtest_ioctl_gen dut0 (
        .clk(clk), .rst(rst), .start(start0), .len(len), .seed(seed),
        .dwnld_busy(dwnld_busy), .downloading(dl0), .ioctl_addr(addr0),
        .ioctl_dout(dout0), .ioctl_wr(wr0), .pass(pass0), .busy(busy0), .done(done0)
    );

    jtldtest_ioctl_gen #(.WR_PERIOD(4), .GAP_LEN(5), .PATTERN(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .len(len), .seed(seed),
        .dwnld_busy(dwnld_busy), .downloading(dl1), .ioctl_addr(addr1),
        .ioctl_dout(dout1), .ioctl_wr(wr1), .pass(pass1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int sel);
        if (sel == 0) begin
            o_dl = dl0; o_wr = wr0; o_pass = pass0; o_busy = busy0;
            o_done = done0; o_addr = addr0; o_dout = dout0;
        end else begin
            o_dl = dl1; o_wr = wr1; o_pass = pass1; o_busy = busy1;
            o_done = done1; o_addr = addr1; o_dout = dout1;
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else start1 = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full two-pass sequence. dwnld_busy is high on the posedges at
    // offsets 1..r after the accepting edge, so it stretches pass 0's flush.
    task automatic run_seq(input int sel, input int ln, input logic [7:0] sd,
                           input int r, input bit hold_start);
        logic [7:0] eb[$];
        logic [7:0] b;
        int wp, gl, rel, budget, last_wr, p1_rel, gap_low, tail_low, done_cnt, idx;
        int wcnt[2];
        int hi_cnt[2];
        bit fin_seen;
        wp = (sel == 0) ? 8 : 4;
        gl = (sel == 0) ? 16 : 5;
        b = (sd == 8'h00) ? 8'h01 : sd;
        for (int i = 0; i < ln; i++) begin
            if (sel == 1) eb.push_back(8'(i % 256));
            else begin
                eb.push_back(b);
                b = {b[6:0], ^(b & 8'hB8)};
            end
        end
        rel = 0; last_wr = 0; p1_rel = -1; gap_low = 0; tail_low = 0; done_cnt = 0;
        wcnt[0] = 0; wcnt[1] = 0; hi_cnt[0] = 0; hi_cnt[1] = 0; fin_seen = 1'b0;
        budget = 4 * ln * wp + 2 * gl + r + 50;

        len = 25'(ln);
        seed = sd;
        dwnld_busy = (r >= 1);
        set_start(sel, 1'b1);
        tick();
        if (!hold_start) set_start(sel, 1'b0);

        while (rel < budget) begin
            sample(sel);
            if (hold_start) begin
                len = 25'($urandom);
                seed = 8'($urandom);
            end
            if (fin_seen) begin
                chk("idle_busy", o_busy, 0);
                chk("idle_pass", o_pass, 0);
                chk("idle_dl", o_dl, 0);
                break;
            end
            chk("busy_run", o_busy, 1);
            if (rel == 0) begin
                chk("entry0_dl", o_dl, 1);
                chk("entry0_addr", o_addr, 0);
                chk("entry0_pass", o_pass, 0);
            end
            if (o_pass && p1_rel < 0) begin
                p1_rel = rel;
                chk("entry1_dl", o_dl, 1);
                chk("entry1_addr", o_addr, 0);
            end
            if (o_dl) begin
                hi_cnt[o_pass]++;
                idx = int'(o_addr);
                if (idx < ln) chk("dout", o_dout, eb[idx]);
                else chk("addr_range", o_addr, 25'(ln - 1));
            end else if (!o_pass) gap_low++;
            else tail_low++;
            if (o_wr) begin
                chk("wr_dl", o_dl, 1);
                chk("wr_addr", o_addr, 25'(wcnt[o_pass]));
                if (wcnt[o_pass] == 0)
                    chk("wr_first", rel, (o_pass ? p1_rel : 0) + 1);
                else
                    chk("wr_spacing", rel - last_wr, wp);
                wcnt[o_pass]++;
                last_wr = rel;
            end
            if (o_done) begin
                done_cnt++;
                fin_seen = 1'b1;
                set_start(sel, 1'b0);
            end
            dwnld_busy = (rel + 1 <= r);
            tick();
            rel++;
        end
        set_start(sel, 1'b0);
        dwnld_busy = 1'b0;
        chk("seq_finished", fin_seen, 1);
        chk("wr_count_p0", wcnt[0], ln);
        chk("wr_count_p1", wcnt[1], ln);
        chk("dl_high_p0", hi_cnt[0], ln * wp + 1 + ((r > ln * wp) ? r - ln * wp : 0));
        chk("dl_high_p1", hi_cnt[1], ln * wp + 1);
        chk("gap_low", gap_low, gl);
        chk("tail_low", tail_low, gl + 1);
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        int ln, r, waited;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; dwnld_busy = 1'b0;
        len = 25'd0; seed = 8'd0;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            sample(s);
            chk("rst_dl", o_dl, 0);
            chk("rst_wr", o_wr, 0);
            chk("rst_addr", o_addr, 0);
            chk("rst_dout", o_dout, 0);
            chk("rst_pass", o_pass, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
        end
        rst = 1'b0;
        tick();

        len = 25'd0;
        start0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("len0_busy", busy0, 0);
        end
        start0 = 1'b0;

        run_seq(0, 4, 8'hA5, 0, 1'b0);
        run_seq(0, 3, 8'($urandom), 0, 1'b0);
        run_seq(0, 2, 8'($urandom), 2 * 8 + 20, 1'b0);
        run_seq(0, 3, 8'h00, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ln = $urandom_range(1, 6);
            r = $urandom_range(0, ln * 8 + 10);
            run_seq(0, ln, 8'($urandom), r, 1'($urandom));
        end

        // Abort mid pass 1, then replay from scratch.
        len = 25'd5;
        seed = 8'($urandom);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        waited = 0;
        while (!(pass0 && addr0 == 25'd2) && waited < 500) begin
            tick();
            waited++;
        end
        chk("abort_reached", waited < 500, 1);
        rst = 1'b1;
        tick();
        chk("abort_dl", dl0, 0);
        chk("abort_pass", pass0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_wr", wr0, 0);
        chk("abort_addr", addr0, 0);
        chk("abort_done", done0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_nodone", done0, 0);
        end
        rst = 1'b0;
        tick();
        run_seq(0, 5, 8'($urandom), 0, 1'b0);

        run_seq(1, 300, 8'($urandom), 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
